// File: rtl/util_gpsdo_dac_spi.sv
// SPI master that writes 24-bit frames to the AD5683 VCXO-trim DAC of the GPSDO.
// Optionally sends one control-register frame after reset, then streams loop-filter codes.
module util_gpsdo_dac_spi #(
    parameter int          CLK_DIV   = 4,
    parameter int          SYNC_IDLE = 4,
    parameter logic [3:0]  CMD_WRITE = 4'b0011,
    parameter bit          INIT_EN   = 1'b1,
    parameter logic [15:0] INIT_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] dac_data,
    input  logic        dac_valid,
    output logic        dac_ready,
    output logic        frame_done,
    output logic        busy,
    output logic        sclk,
    output logic        mosi,
    output logic        sync_n
);

    localparam int HALF_W = $clog2(CLK_DIV) + 1;
    localparam int GAP_W  = $clog2(SYNC_IDLE) + 1;

    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(SYNC_IDLE - 1);
    localparam logic [4:0]        BIT_LAST  = 5'd23;
    localparam logic [3:0]        CMD_CTRL  = 4'b0100;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    localparam state_t RESET_STATE = INIT_EN ? ST_INIT : ST_IDLE;

    state_t             state_q, state_d;
    logic [22:0]        shift_q, shift_d;
    logic [HALF_W-1:0]  half_q, half_d;
    logic [4:0]         bit_q, bit_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               sync_n_q, sync_n_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;
    logic               load;
    logic [23:0]        frame;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path infers a latch.
        state_d  = state_q;
        shift_d  = shift_q;
        half_d   = half_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        sync_n_d = sync_n_q;
        done_d   = 1'b0;
        load     = 1'b0;
        frame    = '0;

        case (state_q)
            ST_INIT: begin
                load  = 1'b1;
                frame = {CMD_CTRL, INIT_WORD, 4'b0000};
            end
            ST_IDLE: begin
                if (dac_valid && ready_q) begin
                    load  = 1'b1;
                    frame = {CMD_WRITE, dac_data, 4'b0000};
                end
            end
            ST_SHIFT: begin
                if (half_q == HALF_LAST) begin
                    half_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (bit_q == BIT_LAST) begin
                        // End of the 24th low phase: release the bus and flag completion together.
                        sclk_d   = 1'b1;
                        sync_n_d = 1'b1;
                        mosi_d   = 1'b0;
                        done_d   = 1'b1;
                        gap_d    = '0;
                        state_d  = ST_GAP;
                    end else begin
                        sclk_d  = 1'b1;
                        mosi_d  = shift_q[22];
                        shift_d = {shift_q[21:0], 1'b0};
                        bit_d   = bit_q + 5'd1;
                    end
                end else begin
                    half_d = half_q + HALF_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = RESET_STATE;
        endcase

        // The MSB goes out on the first frame cycle; the register keeps the remaining 23 bits.
        if (load) begin
            state_d  = ST_SHIFT;
            shift_d  = frame[22:0];
            mosi_d   = frame[23];
            sclk_d   = 1'b1;
            sync_n_d = 1'b0;
            half_d   = '0;
            bit_d    = '0;
        end

        ready_d = (state_d == ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= RESET_STATE;
            shift_q  <= '0;
            half_q   <= '0;
            bit_q    <= '0;
            gap_q    <= '0;
            sclk_q   <= 1'b1;
            mosi_q   <= 1'b0;
            sync_n_q <= 1'b1;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            half_q   <= half_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            sync_n_q <= sync_n_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign dac_ready  = ready_q;
    assign frame_done = done_q;
    assign busy       = (state_q != ST_IDLE);
    assign sclk       = sclk_q;
    assign mosi       = mosi_q;
    assign sync_n     = sync_n_q;

endmodule

// File: tb/tb_util_gpsdo_dac_spi.sv
// Bench for util_gpsdo_dac_spi: a slow instance (defaults) and a fast one (CLK_DIV=1, SYNC_IDLE=1, no init),
// each checked every cycle against a frame-timing model and a DAC-side receiver.
module tb_util_gpsdo_dac_spi;

    localparam logic [3:0]  CMD       = 4'b0011;
    localparam logic [15:0] INIT_WORD = 16'h0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  resetn_v;
    logic [1:0]  valid_v;
    logic [15:0] data_v [2];
    wire  [1:0]  ready_v, done_v, busy_v, sclk_v, mosi_v, sync_v;

    int n_checks = 0;
    int n_errors = 0;
    int gcyc     = 0;

    always @(posedge clk) gcyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    util_gpsdo_dac_spi #(
        .CLK_DIV(4), .SYNC_IDLE(4), .CMD_WRITE(CMD), .INIT_EN(1'b1), .INIT_WORD(INIT_WORD)
    ) u_dut_slow (
        .clk(clk), .resetn(resetn_v[0]), .dac_data(data_v[0]), .dac_valid(valid_v[0]),
        .dac_ready(ready_v[0]), .frame_done(done_v[0]), .busy(busy_v[0]),
        .sclk(sclk_v[0]), .mosi(mosi_v[0]), .sync_n(sync_v[0])
    );

    util_gpsdo_dac_spi #(
        .CLK_DIV(1), .SYNC_IDLE(1), .CMD_WRITE(CMD), .INIT_EN(1'b0), .INIT_WORD(INIT_WORD)
    ) u_dut_fast (
        .clk(clk), .resetn(resetn_v[1]), .dac_data(data_v[1]), .dac_valid(valid_v[1]),
        .dac_ready(ready_v[1]), .frame_done(done_v[1]), .busy(busy_v[1]),
        .sclk(sclk_v[1]), .mosi(mosi_v[1]), .sync_n(sync_v[1])
    );

    for (genvar g = 0; g < 2; g++) begin : gen_chk
        localparam int D  = (g == 0) ? 4 : 1;
        localparam int S  = (g == 0) ? 4 : 1;
        localparam bit IE = (g == 0);

        // Model: c counts cycles since reset release; a frame starting at m_start occupies
        // 48*D cycles, then one done cycle, then the gap, then ready.
        int          c       = 0;
        int          m_start = -100000;
        logic [23:0] m_frame = '0;
        logic [23:0] exp_q[$];

        int          completed = 0;
        int          aborted   = 0;
        int          rx_bits   = 0;
        logic [23:0] rx_word   = '0;
        logic [23:0] last_word = '0;
        int          fall_cyc  = 0;
        int          rise_cyc  = 0;
        int          low_len   = 0;
        int          high_len  = 0;
        logic [5:0]  pins_act;
        logic [5:0]  pins_exp;

        function automatic bit m_ready(int cc);
            return (cc >= 1) && (cc >= m_start + 48 * D + S);
        endfunction

        // Packed as {ready, busy, frame_done, sclk, mosi, sync_n}.
        function automatic logic [5:0] m_out(int cc);
            int k;
            k = cc - m_start;
            if (k < 0)          return 6'b010101;
            if (k < 48 * D)     return {3'b010, ((k / D) % 2) == 0, m_frame[23 - k / (2 * D)], 1'b0};
            if (k == 48 * D)    return 6'b011101;
            if (k < 48 * D + S) return 6'b010101;
            return {m_ready(cc), 5'b00101};
        endfunction

        always @(posedge clk or negedge resetn_v[g]) begin
            if (!resetn_v[g]) begin
                c = 0;
                exp_q.delete();
                if (IE) begin
                    m_start = 1;
                    m_frame = {4'b0100, INIT_WORD, 4'b0000};
                    exp_q.push_back(m_frame);
                end else begin
                    m_start = -100000;
                end
            end else begin
                if (m_ready(c) && valid_v[g]) begin
                    m_frame = {CMD, data_v[g], 4'b0000};
                    m_start = c + 1;
                    exp_q.push_back(m_frame);
                end
                c++;
            end
        end

        // The wake-up cycle right after release without an init frame is not pinned for ready.
        always @(negedge clk) begin
            pins_act = {ready_v[g], busy_v[g], done_v[g], sclk_v[g], mosi_v[g], sync_v[g]};
            pins_exp = m_out(c);
            if (!IE && c == 0)
                check($sformatf("pins%0d", g), 32'(pins_act[4:0]), 32'(pins_exp[4:0]));
            else
                check($sformatf("pins%0d", g), 32'(pins_act), 32'(pins_exp));
        end

        // DAC-side receiver: samples mosi on falling sclk while sync_n is low.
        always @(negedge sclk_v[g]) begin
            if (!sync_v[g]) begin
                rx_word = {rx_word[22:0], mosi_v[g]};
                rx_bits++;
            end
        end

        always @(negedge sync_v[g]) begin
            rx_bits  = 0;
            fall_cyc = gcyc;
            high_len = gcyc - rise_cyc;
        end

        always @(posedge sync_v[g]) begin
            rise_cyc = gcyc;
            low_len  = gcyc - fall_cyc;
            if (rx_bits == 24) begin
                completed++;
                last_word = rx_word;
                if (exp_q.size() == 0)
                    check($sformatf("dac_word_unexpected%0d", g), 32'(rx_word), 32'hFFFF_FFFF);
                else
                    check($sformatf("dac_word%0d", g), 32'(rx_word), 32'(exp_q.pop_front()));
            end else begin
                aborted++;
            end
        end
    end

    task automatic wait_ready(input int g, input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready_v[g] && n < limit);
        if (!ready_v[g]) check($sformatf("ready_timeout%0d", g), 32'(ready_v[g]), 32'd1);
    endtask

    task automatic wait_done(input int g, input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done_v[g] && n < limit);
        if (!done_v[g]) check($sformatf("done_timeout%0d", g), 32'(done_v[g]), 32'd1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : seq
        int n;
        int t1;
        int t2;
        int base_c;
        int base_a;

        resetn_v  = 2'b00;
        valid_v   = 2'b00;
        data_v[0] = '0;
        data_v[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pins_slow", 32'({ready_v[0], busy_v[0], done_v[0], sclk_v[0], mosi_v[0], sync_v[0]}), 32'h15);
        check("reset_pins_fast", 32'({ready_v[1], busy_v[1], done_v[1], sclk_v[1], mosi_v[1], sync_v[1]}), 32'h05);

        // Release with a code already offered: the init frame goes first.
        data_v[0]  = 16'h1111;
        valid_v[0] = 1'b1;
        base_c     = gen_chk[0].completed;
        resetn_v   = 2'b11;
        wait_ready(0, 400, n);
        check("init_ready_latency", 32'(n), 32'd197);
        check("init_frame_count", 32'(gen_chk[0].completed - base_c), 32'd1);
        check("init_word", 32'(gen_chk[0].last_word), 32'h0040_0000);
        @(posedge clk);
        #1;
        valid_v[0] = 1'b0;
        wait_done(0, 400, n);
        check("held_valid_word", 32'(gen_chk[0].last_word), 32'h0031_1110);

        // Single code; data and valid wiggle while busy and must not matter.
        wait_ready(0, 400, n);
        data_v[0]  = 16'hA5C3;
        valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        check("a5c3_start_sync_n", 32'(sync_v[0]), 32'd0);
        check("a5c3_start_mosi", 32'(mosi_v[0]), 32'd0);
        data_v[0] = 16'h1234;
        n = 1;
        while (!done_v[0] && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 20) valid_v[0] = 1'b0;
        end
        check("a5c3_done_offset", 32'(n), 32'd193);
        check("a5c3_sync_low", 32'(gen_chk[0].low_len), 32'd192);
        check("a5c3_word", 32'(gen_chk[0].last_word), 32'h003A_5C30);

        // Back-to-back with valid held high.
        wait_ready(0, 400, n);
        data_v[0]  = 16'h0001;
        valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        t1        = gcyc;
        data_v[0] = 16'hFFFF;
        wait_done(0, 400, n);
        check("b2b_first_word", 32'(gen_chk[0].last_word), 32'h0030_0010);
        wait_ready(0, 400, n);
        @(posedge clk);
        #1;
        t2         = gcyc;
        valid_v[0] = 1'b0;
        check("b2b_accept_spacing", 32'(t2 - t1), 32'd197);
        wait_done(0, 400, n);
        check("b2b_sync_high", 32'(gen_chk[0].high_len), 32'd5);
        check("b2b_second_word", 32'(gen_chk[0].last_word), 32'h003F_FFF0);

        // Fastest configuration, back-to-back.
        wait_ready(1, 400, n);
        data_v[1]  = 16'h8001;
        valid_v[1] = 1'b1;
        @(posedge clk);
        #1;
        t1        = gcyc;
        data_v[1] = 16'h7FFE;
        wait_done(1, 400, n);
        check("fast_first_word", 32'(gen_chk[1].last_word), 32'h0038_0010);
        check("fast_sync_low", 32'(gen_chk[1].low_len), 32'd48);
        wait_ready(1, 400, n);
        @(posedge clk);
        #1;
        t2         = gcyc;
        valid_v[1] = 1'b0;
        check("fast_accept_spacing", 32'(t2 - t1), 32'd50);
        wait_done(1, 400, n);
        check("fast_sync_high", 32'(gen_chk[1].high_len), 32'd2);
        check("fast_second_word", 32'(gen_chk[1].last_word), 32'h0037_FFE0);

        // Reset after the 10th falling edge of a frame.
        wait_ready(0, 400, n);
        data_v[0]  = 16'h5A5A;
        valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        valid_v[0] = 1'b0;
        n = 0;
        while (gen_chk[0].rx_bits < 10 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort_fall_count", 32'(gen_chk[0].rx_bits), 32'd10);
        base_c      = gen_chk[0].completed;
        base_a      = gen_chk[0].aborted;
        resetn_v[0] = 1'b0;
        #1;
        check("abort_sync_n", 32'(sync_v[0]), 32'd1);
        check("abort_sclk", 32'(sclk_v[0]), 32'd1);
        check("abort_frame_done", 32'(done_v[0]), 32'd0);
        check("abort_no_write", 32'(gen_chk[0].completed - base_c), 32'd0);
        check("abort_seen", 32'(gen_chk[0].aborted - base_a), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        resetn_v[0] = 1'b1;
        wait_ready(0, 400, n);
        check("replay_ready_latency", 32'(n), 32'd197);
        check("replay_word", 32'(gen_chk[0].last_word), 32'h0040_0000);
        check("replay_frame_count", 32'(gen_chk[0].completed - base_c), 32'd1);

        repeat (5) @(posedge clk);
        #1;
        check("slow_queue_drained", 32'(gen_chk[0].exp_q.size()), 32'd0);
        check("fast_queue_drained", 32'(gen_chk[1].exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/util_gpsdo_dac_spi.md
Name: util_gpsdo_dac_spi

Overview:
- SPI master that writes 16-bit tuning codes to the AD5683 VCXO-trim DAC of the GPSDO.
- Consumes the DAC code produced by the reference-PLL loop filter over a valid/ready handshake.
- Drives the DAC's sclk/mosi/sync_n pins directly.
- Optionally issues one control-register write after reset, before accepting codes.

Parameters:
- CLK_DIV, 4: sclk half-period in clk cycles, >= 1; at 200 MHz clk this gives 25 MHz sclk.
- SYNC_IDLE, 4: minimum sync_n high time between frames, in clk cycles, >= 1.
- CMD_WRITE, 4'b0011: command nibble for normal frames (write and update DAC register).
- INIT_EN, 1: 1 = send one control frame after reset release.
- INIT_WORD, 16'h0000: payload of the init frame; command nibble fixed 4'b0100.

Ports:
- clk  in  1  system clock (200 MHz domain of the reference PLL)
- resetn  in  1  asynchronous active-low reset
- dac_data  in  16  DAC code, offset binary
- dac_valid  in  1  dac_data valid; upstream holds data and valid until accepted
- dac_ready  out  1  block can accept a code
- frame_done  out  1  one-cycle pulse when a frame completes (sync_n rises)
- busy  out  1  high whenever state != IDLE
- sclk  out  1  SPI clock to AD5683, idles high
- mosi  out  1  SPI data, MSB first
- sync_n  out  1  AD5683 SYNC, active low

Behaviour:
- Reset (async, resetn=0): sclk=1, mosi=0, sync_n=1, dac_ready=0, frame_done=0, busy=1 if INIT_EN else 0; state = INIT if INIT_EN else IDLE.
- Frame format: 24 bits, {cmd[3:0], data[15:0], 4'b0000}, shifted MSB first.
- States: INIT, IDLE, SHIFT, GAP.
  - INIT: on the first cycle after reset release, load {4'b0100, INIT_WORD, 4'b0} and go to SHIFT.
  - IDLE: dac_ready=1. On cycle T with dac_valid && dac_ready, latch {CMD_WRITE, dac_data, 4'b0} and go to SHIFT. dac_ready=0 from T+1.
- SHIFT phase (frame start is T+1):
  - At T+1: sync_n=0 and mosi=bit23.
  - Each bit: sclk high for CLK_DIV cycles, then low for CLK_DIV cycles. The DAC samples on the falling edge.
  - mosi changes only on the cycle sclk rises, or at frame start.
  - After the 24th low phase, on the same cycle: sclk=1, sync_n=1, mosi=0, frame_done=1; go to GAP.
  - sync_n is low for exactly 48*CLK_DIV cycles.
- GAP: hold idle outputs for SYNC_IDLE cycles, then IDLE with dac_ready=1.
  - Defaults: sync_n low T+1..T+192; frame_done at T+193; dac_ready=1 at T+197.
  - Accept-to-accept minimum = 1 + 48*CLK_DIV + SYNC_IDLE cycles.
- Back-to-back: if dac_valid is held high, the next frame is accepted on the first cycle dac_ready=1. No bubble beyond GAP.
- dac_valid while dac_ready=0 is ignored; no internal buffering.
- Changes to dac_data after acceptance do not affect the frame in flight.
- Internal counters: half-period counter of width clog2(CLK_DIV)+1; bit counter of 5 bits, 0..23, no wrap past 23.
- Reset mid-frame:
  - Outputs return to reset values immediately and asynchronously.
  - The DAC sees sync_n rise before 24 falling edges and discards the partial frame.
  - The init frame is re-sent if INIT_EN=1.
- Reset released with dac_valid already high and INIT_EN=1: the init frame goes first; the code is accepted in IDLE.
- frame_done is never asserted for a frame aborted by reset.

Test Plan:
- Reset, INIT_EN=1, INIT_WORD=16'h0000 -> 24 falling sclk edges; mosi sequence 0100 followed by 20 zeros; dac_ready rises 1+192+4 cycles after reset release.
- dac_data=16'hA5C3 accepted at T -> bits sampled on falling edges = 0011_1010_0101_1100_0011_0000; sync_n low T+1..T+192; frame_done at T+193.
- dac_valid held high with codes 16'h0001 then 16'hFFFF -> second acceptance exactly 197 cycles after the first; both frames bit-exact; sync_n high >= 4 cycles between frames.
- CLK_DIV=1, SYNC_IDLE=1 -> sclk toggles every cycle; sync_n low exactly 48 cycles; accept-to-accept exactly 50 cycles.
- resetn pulsed low after 10 falling edges -> sync_n=1 and sclk=1 in the same cycle; no frame_done; checker records no completed DAC write; the init frame then replays.
- dac_data changed while busy -> transmitted bits match the value latched at acceptance; dac_valid while dac_ready=0 causes no state change.
